// File: rtl/alu_op_sequencer.sv
// Initiator for one combinational alu: buffers valid/ready commands in a FIFO, issues them one at
// a time and returns captured results in command order with an error flag.
module alu_op_sequencer #(
  parameter int unsigned DATASIZE   = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned SELSIZE   = 4,
  localparam int unsigned PW        = $clog2(FIFO_DEPTH),
  localparam int unsigned CW        = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [SELSIZE-1:0]    cmd_op,
  input  logic [DATASIZE-1:0]   cmd_a,
  input  logic [DATASIZE-1:0]   cmd_b,
  output logic [DATASIZE-1:0]   alu_in1,
  output logic [DATASIZE-1:0]   alu_in2,
  output logic [SELSIZE-1:0]    alu_sel,
  input  logic [2*DATASIZE-1:0] alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATASIZE-1:0] rsp_data,
  output logic [SELSIZE-1:0]    rsp_op,
  output logic                  rsp_err,
  output logic [CW-1:0]         fifo_count
);

  localparam logic [SELSIZE-1:0] OpNop = 4'd0;
  localparam logic [SELSIZE-1:0] OpDiv = 4'd4;
  localparam logic [SELSIZE-1:0] OpXor = 4'd10;

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e state_q, state_d;

  logic [SELSIZE-1:0]  fifo_op [FIFO_DEPTH];
  logic [DATASIZE-1:0] fifo_a  [FIFO_DEPTH];
  logic [DATASIZE-1:0] fifo_b  [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                push, pop, fifo_empty;

  logic [SELSIZE-1:0]    op_q;
  logic [DATASIZE-1:0]   a_q, b_q;
  logic                  op_legal, div_zero;
  logic [2*DATASIZE-1:0] rsp_data_q;
  logic [SELSIZE-1:0]    rsp_op_q;
  logic                  rsp_err_q;

  // Ready depends only on the registered count, so a pop never opens a same-cycle slot.
  assign cmd_ready  = (count_q != CW'(FIFO_DEPTH));
  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign push       = cmd_valid && cmd_ready;

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = !fifo_empty;
      StResp:  pop = rsp_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op[wr_ptr_q] <= cmd_op;
      fifo_a[wr_ptr_q]  <= cmd_a;
      fifo_b[wr_ptr_q]  <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= OpNop;
      a_q  <= '0;
      b_q  <= '0;
    end else if (pop) begin
      op_q <= fifo_op[rd_ptr_q];
      a_q  <= fifo_a[rd_ptr_q];
      b_q  <= fifo_b[rd_ptr_q];
    end
  end

  assign op_legal = (op_q <= OpXor);
  assign div_zero = (op_q == OpDiv) && (b_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StDrive;
      StDrive: state_d = StResp;
      StResp:  if (rsp_ready) state_d = fifo_empty ? StIdle : StDrive;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_in1   = '0;
    alu_in2   = '0;
    alu_sel   = OpNop;
    rsp_valid = (state_q == StResp);
    if (state_q == StDrive) begin
      alu_in1 = a_q;
      alu_in2 = b_q;
      alu_sel = op_legal ? op_q : OpNop;
    end
  end

  // Result is captured at the end of the single DRIVE cycle and held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_op_q   <= OpNop;
      rsp_err_q  <= 1'b0;
    end else if (state_q == StDrive) begin
      rsp_op_q <= op_q;
      if (!op_legal) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end else if (div_zero) begin
        rsp_data_q <= '1;
        rsp_err_q  <= 1'b1;
      end else begin
        rsp_data_q <= alu_out;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_op   = rsp_op_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural alu attached.
module tb_alu_op_sequencer;

  localparam logic [3:0] OpNop = 4'd0, OpAdd = 4'd1, OpSub = 4'd2, OpMul = 4'd3, OpDiv = 4'd4;
  localparam logic [3:0] OpSl = 4'd5, OpSr = 4'd6, OpAnd = 4'd7, OpOr = 4'd8, OpNot = 4'd9;
  localparam logic [3:0] OpXor = 4'd10;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic [7:0]  alu_in1, alu_in2;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_op;
  logic        rsp_err;
  logic [2:0]  fifo_count;

  rsp_t sb[$];
  int   hs_cyc[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  alu_op_sequencer #(.DATASIZE(8), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu_fn(input logic [3:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
    case (sel)
      OpNop:   return 16'h0000;
      OpAdd:   return 16'(a) + 16'(b);
      OpSub:   return 16'(a) - 16'(b);
      OpMul:   return 16'(a) * 16'(b);
      OpDiv:   return (b == 8'd0) ? 16'hDEAD : 16'(a / b);
      OpSl:    return 16'(a) << 1;
      OpSr:    return 16'(a >> 1);
      OpAnd:   return 16'(a & b);
      OpOr:    return 16'(a | b);
      OpNot:   return ~16'(a);
      OpXor:   return 16'(a ^ b);
      default: return 16'hBAD0;
    endcase
  endfunction

  always_comb alu_out = alu_fn(alu_sel, alu_in1, alu_in2);

  function automatic rsp_t exp_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    rsp_t r;
    r.op = op;
    if (op > OpXor) begin
      r.data = 16'h0000;
      r.err  = 1'b1;
    end else if (op == OpDiv && b == 8'd0) begin
      r.data = 16'hFFFF;
      r.err  = 1'b1;
    end else begin
      r.data = alu_fn(op, a, b);
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_op", 32'(rsp_op), 32'(e.op));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Holds the command until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back(exp_fn(op, a, b));
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      t++;
      if (t > 50) begin
        check("send_timeout", 32'(cmd_ready), 32'd1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < hs_cyc.size(); i++) begin
      check(tag, 32'(hs_cyc[i] - hs_cyc[i-1]), 32'd2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = OpNop;
    cmd_a = 8'h00;
    cmd_b = 8'h00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_op", 32'(rsp_op), 32'(OpNop));
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_alu_sel", 32'(alu_sel), 32'(OpNop));
    check("rst_alu_in1", 32'(alu_in1), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ADD latency and single-cycle drive
    rsp_ready = 1'b1;
    cmd_op = OpAdd;
    cmd_a = 8'hF0;
    cmd_b = 8'h20;
    cmd_valid = 1'b1;
    @(negedge clk);
    check("add_cmd_ready", 32'(cmd_ready), 32'd1);
    sb.push_back(exp_fn(OpAdd, 8'hF0, 8'h20));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("add_sel_idle", 32'(alu_sel), 32'(OpNop));
    check("add_valid_n1", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("add_sel_drive", 32'(alu_sel), 32'(OpAdd));
    check("add_in1_drive", 32'(alu_in1), 32'hF0);
    check("add_valid_n2", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    check("add_valid", 32'(rsp_valid), 32'd1);
    check("add_data", 32'(rsp_data), 32'h0110);
    check("add_sel_resp", 32'(alu_sel), 32'(OpNop));
    @(posedge clk);
    #1;
    check("add_valid_done", 32'(rsp_valid), 32'd0);
    drain();

    // Divide by zero and illegal opcode
    send(OpDiv, 8'd9, 8'd0);
    drain();
    send(4'd12, 8'h55, 8'h66);
    repeat (3) begin
      @(negedge clk);
      check("illegal_sel_nop", 32'(alu_sel), 32'(OpNop));
    end
    drain();

    // Back-pressure fill, then full-FIFO pop cycle
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(OpMul, 8'(i + 2), 8'(i + 13));
    cmd_op = OpMul;
    cmd_a = 8'd7;
    cmd_b = 8'd9;
    cmd_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_fifo_count", 32'(fifo_count), 32'd4);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    hs_cyc.delete();
    @(negedge clk);
    check("full_pop_ready", 32'(cmd_ready), 32'd0);
    check("full_pop_count", 32'(fifo_count), 32'd4);
    @(posedge clk);
    #1;
    check("after_pop_count", 32'(fifo_count), 32'd3);
    send(OpMul, 8'd7, 8'd9);
    drain();
    check("bp_rsp_total", 32'(hs_cyc.size()), 32'd6);
    check_spacing("bp_spacing");

    // Streaming SUB, SL, NOT back to back
    hs_cyc.delete();
    send(OpSub, 8'd5, 8'd3);
    send(OpSl, 8'h81, 8'd1);
    send(OpNot, 8'h0F, 8'd0);
    drain();
    check("stream_count", 32'(hs_cyc.size()), 32'd3);
    check_spacing("stream_spacing");

    // Random ops under random back-pressure
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 3)));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    #0;
    rsp_ready = 1'b1;
    drain();

    // Asynchronous reset while a response is pending
    rsp_ready = 1'b0;
    send(OpAdd, 8'd1, 8'd2);
    send(OpXor, 8'hAA, 8'h0F);
    repeat (2) @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_alu_sel", 32'(alu_sel), 32'(OpNop));
    check("arst_fifo_count", 32'(fifo_count), 32'd0);
    check("arst_rsp_data", 32'(rsp_data), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    send(OpAnd, 8'hF3, 8'h3C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
